ram_bist: RTL and testbench

Built-in self-test engine that is the initiator side of the single-port `ram` interface (`cen`/`wen`/`addr`/`din`/`dout`). On `start`, it performs three steps. First, it writes a selectable data pattern to every word. Second, it reads every word back. Third, it compares each read word against the expected value and reports pass/fail, the first failing address and the error count. It sits between the test/debug controller and the `ram` instance, and owns the RAM port while `busy`.

---
 rtl/ram_bist_pkg.sv | 24 ++
 rtl/ram_bist_if.sv | 20 ++
 rtl/ram_bist_pattern.sv | 31 +++
 rtl/ram_bist.sv | 196 +++++++++++++++++++
 tb/tb_ram_bist.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared types and constants for the RAM BIST engine.
//   state_e  - controller states (IDLE, WRITE, READ, DRAIN, DONE)
//   PAT_*    - pattern_sel encodings
//   DEF_*    - default geometry (32 words x 32 bits)
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [1:0] PAT_ADDR = 2'd0;
  localparam logic [1:0] PAT_INV  = 2'd1;
  localparam logic [1:0] PAT_CHK  = 2'd2;
  localparam logic [1:0] PAT_ONES = 2'd3;

  localparam int DEF_DEPTH = 32;
  localparam int DEF_AW    = 5;
  localparam int DEF_DW    = 32;

endpackage

// File: rtl/ram_bist_if.sv
// ram_bist_if: single-port RAM bus between the BIST engine and the RAM.
//   cen  - chip enable
//   wen  - 1 = write, 0 = read
//   addr - word address
//   din  - write data
//   dout - read data (returned by the RAM)
// Modports: master = BIST/initiator side, slave = RAM side.
interface ram_bist_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          cen;
  logic          wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;

  modport master (output cen, output wen, output addr, output din, input dout);
  modport slave  (input cen, input wen, input addr, input din, output dout);
endinterface

// File: rtl/ram_bist_pattern.sv
// ram_bist_pattern: combinational test-pattern generator.
//   pattern_sel - pattern code (PAT_ADDR, PAT_INV, PAT_CHK, PAT_ONES)
//   addr        - word address
//   data        - pattern word for that address
module ram_bist_pattern
  import ram_bist_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic [1:0]    pattern_sel,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  always_comb begin
    data = '0;
    case (pattern_sel)
      PAT_ADDR: data = DW'(addr);
      PAT_INV:  data = ~DW'(addr);
      // Odd bit positions set on even addresses (0xAA..), even bits on odd.
      PAT_CHK: begin
        for (int i = 0; i < DW; i++) begin
          data[i] = addr[0] ^ ((i % 2) == 1);
        end
      end
      default:  data = '1;
    endcase
  end

endmodule

// File: rtl/ram_bist.sv
// ram_bist: march-style write/read/compare BIST for a single-port RAM.
//   clk, rst_n   - clock, async active-low reset
//   start        - one-cycle run request (IDLE only)
//   abort        - stop a run in progress
//   pattern_sel  - pattern code, captured on start acceptance
//   ram          - RAM bus (master modport), all outputs registered
//   busy, done   - run in progress / one-cycle completion pulse
//   pass         - last completed run had no mismatches
//   fail_addr    - first mismatching address of the last run
//   err_count    - number of mismatching words of the last run
//
// state | meaning
// IDLE  | waiting for start, RAM port parked
// WRITE | writing pattern(addr), addr 0..DEPTH-1
// READ  | issuing reads, addr 0..DEPTH-1
// DRAIN | waiting RD_LAT cycles for the last read data
// DONE  | done pulse, pass valid
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    pattern_sel,
  ram_bist_if.master    ram,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [AW:0]   err_count
);

  localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e         state_q, state_nx;
  logic           cen_q, wen_q, cen_nx, wen_nx;
  logic [AW-1:0]  addr_q, addr_nx;
  logic [DW-1:0]  din_q, din_nx, din_pat, exp_pat;
  logic [1:0]     pat_q, din_sel;
  logic [DCW-1:0] drain_q;
  logic           start_ok, flush, mism;
  logic [AW:0]    err_nx;

  logic           pipe_vld  [RD_LAT];
  logic [AW-1:0]  pipe_addr [RD_LAT];
  logic [DW-1:0]  pipe_exp  [RD_LAT];

  assign start_ok = (state_q == IDLE) && start && !abort;
  assign flush    = abort && ((state_q == WRITE) || (state_q == READ) || (state_q == DRAIN));

  // Write data is registered with the address, so it is generated from the
  // next address; on the accepting cycle pat_q is not loaded yet.
  assign din_sel = (state_q == IDLE) ? pattern_sel : pat_q;

  ram_bist_pattern #(.AW(AW), .DW(DW)) u_pat_din (
    .pattern_sel (din_sel),
    .addr        (addr_nx),
    .data        (din_pat)
  );

  ram_bist_pattern #(.AW(AW), .DW(DW)) u_pat_exp (
    .pattern_sel (pat_q),
    .addr        (addr_q),
    .data        (exp_pat)
  );

  always_comb begin
    state_nx = state_q;
    cen_nx   = 1'b0;
    wen_nx   = 1'b0;
    addr_nx  = '0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_nx = WRITE;
          cen_nx   = 1'b1;
          wen_nx   = 1'b1;
        end
      end
      WRITE: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (addr_q == LAST_ADDR) begin
          state_nx = READ;
          cen_nx   = 1'b1;
        end else begin
          cen_nx  = 1'b1;
          wen_nx  = 1'b1;
          addr_nx = addr_q + 1'b1;
        end
      end
      READ: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (addr_q == LAST_ADDR) begin
          state_nx = DRAIN;
        end else begin
          cen_nx  = 1'b1;
          addr_nx = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (drain_q == '0) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    din_nx = wen_nx ? din_pat : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cen_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      pat_q   <= PAT_ADDR;
      drain_q <= '0;
    end else begin
      state_q <= state_nx;
      cen_q   <= cen_nx;
      wen_q   <= wen_nx;
      addr_q  <= addr_nx;
      din_q   <= din_nx;
      if (start_ok) pat_q <= pattern_sel;
      if (state_q == READ) begin
        drain_q <= DCW'(RD_LAT - 1);
      end else if ((state_q == DRAIN) && (drain_q != '0)) begin
        drain_q <= drain_q - 1'b1;
      end
    end
  end

  // Read request + expected word, aligned with the RAM's read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_addr[i] <= '0;
        pipe_exp[i]  <= '0;
      end
    end else begin
      pipe_vld[0]  <= cen_q && !wen_q && !flush;
      pipe_addr[0] <= addr_q;
      pipe_exp[0]  <= exp_pat;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1] && !flush;
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_exp[i]  <= pipe_exp[i-1];
      end
    end
  end

  // Case-inequality so X/Z read data counts as a failure.
  assign mism   = pipe_vld[RD_LAT-1] && !flush && (ram.dout !== pipe_exp[RD_LAT-1]);
  assign err_nx = err_count + {{AW{1'b0}}, mism};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass      <= 1'b0;
      fail_addr <= '0;
      err_count <= '0;
    end else if (start_ok) begin
      pass      <= 1'b0;
      fail_addr <= '0;
      err_count <= '0;
    end else begin
      if (mism) begin
        err_count <= err_nx;
        if (err_count == '0) fail_addr <= pipe_addr[RD_LAT-1];
      end
      // err_nx folds in a compare landing in the last DRAIN cycle.
      if ((state_q == DRAIN) && (state_nx == DONE)) pass <= (err_nx == '0);
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign ram.cen  = cen_q;
  assign ram.wen  = wen_q;
  assign ram.addr = addr_q;
  assign ram.din  = din_q;

endmodule

// File: tb/tb_ram_bist.sv
module tb_ram_bist;
  import ram_bist_pkg::*;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] din;
    int          cyc;
  } txn_t;

  typedef struct {
    logic        pass;
    logic [4:0]  fa;
    logic [5:0]  ec;
    int          cyc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        busy, done, pass;
  logic [4:0]  fail_addr;
  logic [5:0]  err_count;

  ram_bist_if #(.AW(5), .DW(32)) bus ();

  ram_bist #(.DEPTH(32), .AW(5), .DW(32), .RD_LAT(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .pattern_sel (pattern_sel),
    .ram         (bus),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_addr   (fail_addr),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: 0 = good, 1 = bit 3 stuck-at-0 at addr 9, 2 = addr 10 never written
  int          fault = 0;
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (bus.cen) begin
      if (bus.wen) begin
        if (!(fault == 2 && bus.addr == 5'd10)) mem[bus.addr] <= bus.din;
      end else begin
        if (fault == 2 && bus.addr == 5'd10)     bus.dout <= 'x;
        else if (fault == 1 && bus.addr == 5'd9) bus.dout <= mem[bus.addr] & ~32'h8;
        else                                     bus.dout <= mem[bus.addr];
      end
    end
  end

  int   errs = 0;
  int   checks = 0;
  txn_t txq[$];
  res_t rsq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat_word(input logic [1:0] p, input logic [4:0] a);
    case (p)
      2'd0:    return {27'd0, a};
      2'd1:    return ~{27'd0, a};
      2'd2:    return a[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Scoreboard monitor: sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && bus.cen) begin
      if (txq.size() == 0) begin
        chk("txn_unexpected", {bus.wen, bus.addr}, 64'h0);
        if (!bus.cen) errs++;
      end else begin
        txn_t e;
        e = txq.pop_front();
        chk("txn_hdr", {bus.wen, bus.addr, cyc[15:0]}, {e.wen, e.addr, e.cyc[15:0]});
        if (e.wen) chk("txn_din", bus.din, e.din);
      end
    end
    if (rst_n && done) begin
      if (rsq.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL done_unexpected: got done=1 expected none (t=%0t)", $time);
      end else begin
        res_t r;
        r = rsq.pop_front();
        chk("done_cycle", cyc, r.cyc);
        chk("done_busy", busy, 1'b1);
        chk("result", {pass, fail_addr, err_count}, {r.pass, r.fa, r.ec});
      end
    end
  end

  // Issue start; expected traffic/results are pushed as the request is made.
  task automatic launch(input logic [1:0] p, input int nwr, input int nrd,
                        input bit with_res, input logic rp, input logic [4:0] rfa,
                        input logic [5:0] rec, output int e0);
    @(negedge clk);
    pattern_sel = p;
    start = 1'b1;
    e0 = cyc + 1;
    for (int a = 0; a < nwr; a++) begin
      txn_t t;
      t.wen = 1'b1; t.addr = 5'(a); t.din = pat_word(p, 5'(a)); t.cyc = e0 + a;
      txq.push_back(t);
    end
    for (int a = 0; a < nrd; a++) begin
      txn_t t;
      t.wen = 1'b0; t.addr = 5'(a); t.din = 32'h0; t.cyc = e0 + 32 + a;
      txq.push_back(t);
    end
    if (with_res) begin
      res_t r;
      r.pass = rp; r.fa = rfa; r.ec = rec; r.cyc = e0 + 65;
      rsq.push_back(r);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errs++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 after %0d cycles", max);
    end
  endtask

  task automatic check_drained(input string name);
    chk({name, "_txq"}, txq.size(), 0);
    chk({name, "_rsq"}, rsq.size(), 0);
  endtask

  task automatic full_run(input logic [1:0] p, input int f, input logic rp,
                          input logic [4:0] rfa, input logic [5:0] rec);
    int e0;
    fault = f;
    launch(p, 32, 32, 1'b1, rp, rfa, rec, e0);
    wait_cyc(e0 + 66);
    chk("busy_after_done", {busy, done}, 2'b00);
    wait_idle(10);
    check_drained("run");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    chk("rst_ram", {bus.cen, bus.wen, bus.addr, bus.din}, 39'h0);
    chk("rst_status", {busy, done, pass, fail_addr, err_count}, 14'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fault-free, address pattern.
    full_run(2'd0, 0, 1'b1, 5'd0, 6'd0);

    // Stuck bit at address 9.
    full_run(2'd0, 1, 1'b0, 5'd9, 6'd1);
    repeat (3) @(negedge clk);
    chk("result_hold", {pass, fail_addr, err_count}, {1'b0, 5'd9, 6'd1});

    // Checkerboard, address 10 never written.
    full_run(2'd2, 2, 1'b0, 5'd10, 6'd1);

    // Inverse pattern, start re-pulsed in cycle 20 and in DONE.
    fault = 0;
    launch(2'd1, 32, 32, 1'b1, 1'b1, 5'd0, 6'd0, e0);
    wait_cyc(e0 + 19);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(e0 + 65);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_dn", {busy, done}, 2'b00);
    repeat (4) @(negedge clk);
    chk("restart_idle", {busy, bus.cen}, 2'b00);
    check_drained("restart");

    // Abort in READ at address 5 (cycle 38).
    launch(2'd3, 32, 6, 1'b0, 1'b0, 5'd0, 6'd0, e0);
    wait_cyc(e0 + 37);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_next", {bus.cen, busy}, 2'b00);
    repeat (4) @(negedge clk);
    chk("abort_result", {pass, err_count}, 7'h0);
    check_drained("abort");

    // start and abort together in IDLE.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    check_drained("start_abort");

    // Reset mid-WRITE at address 12 (cycle 13).
    launch(2'd0, 13, 0, 1'b0, 1'b0, 5'd0, 6'd0, e0);
    wait_cyc(e0 + 12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ram", {bus.cen, bus.wen, bus.addr, bus.din}, 39'h0);
    chk("mid_rst_status", {busy, done, pass, fail_addr, err_count}, 14'h0);
    check_drained("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    full_run(2'd0, 0, 1'b1, 5'd0, 6'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
